// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: eight-subcycle machine-cycle counter, address
// nibble drive during A1..A3, and one/two-word instruction assembly from M1/M2.
module fetch_sequencer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       stall,
   input  logic [3:0] pc_word,
   input  logic       pc_enable,
   input  logic [3:0] bus_in,
   output logic [2:0] cycle,
   output logic       sync,
   output logic [3:0] bus_out,
   output logic       bus_oe,
   output logic [3:0] opr,
   output logic [3:0] opa,
   output logic [7:0] word2,
   output logic       two_word,
   output logic       inst_valid
);

   localparam int unsigned NIB_W = 4;
   localparam int unsigned CYC_W = 3;

   localparam logic [CYC_W-1:0] CYC_A3 = CYC_W'(2);
   localparam logic [CYC_W-1:0] CYC_M1 = CYC_W'(3);
   localparam logic [CYC_W-1:0] CYC_M2 = CYC_W'(4);
   localparam logic [CYC_W-1:0] CYC_X3 = CYC_W'(7);

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } fetch_state_t;

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic [NIB_W-1:0] hi;
   logic             decode;
   logic             load_first;
   logic             load_second;
   logic             valid_next;
   logic             addr_phase;

   // Opcodes that carry a second instruction byte (JCN, FIM, JUN, JMS, ISZ).
   always_comb begin
      decode = 1'b0;
      case (hi)
         4'b0001, 4'b0100, 4'b0101, 4'b0111: decode = 1'b1;
         4'b0010:                            decode = ~bus_in[0];
         default:                            decode = 1'b0;
      endcase
   end

   // Fetch FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= FIRST;
      end else begin
         state <= state_next;
      end
   end

   // Fetch FSM next state; only the M2 subcycle advances the fetch.
   always_comb begin
      state_next  = state;
      load_first  = 1'b0;
      load_second = 1'b0;
      valid_next  = 1'b0;
      if (cycle == CYC_M2) begin
         case (state)
            FIRST: begin
               load_first = 1'b1;
               if (decode) begin
                  state_next = SECOND;
               end else begin
                  valid_next = 1'b1;
               end
            end
            SECOND: begin
               load_second = 1'b1;
               state_next  = FIRST;
               valid_next  = 1'b1;
            end
         endcase
      end
   end

   // Subcycle counter and instruction registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cycle      <= '0;
         hi         <= '0;
         opr        <= '0;
         opa        <= '0;
         word2      <= '0;
         two_word   <= 1'b0;
         inst_valid <= 1'b0;
      end else begin
         cycle      <= (cycle == CYC_X3 && stall) ? cycle : cycle + CYC_W'(1);
         inst_valid <= valid_next;
         if (cycle == CYC_M1) begin
            hi <= bus_in;
         end
         if (load_first) begin
            opr      <= hi;
            opa      <= bus_in;
            two_word <= decode;
         end
         if (load_second) begin
            word2 <= {hi, bus_in};
         end
      end
   end

   // Bus drive is combinational so the PC stack nibble reaches the bus in-cycle.
   always_comb begin
      addr_phase = (cycle <= CYC_A3);
      sync       = (cycle == CYC_X3);
      bus_oe     = addr_phase & pc_enable;
      bus_out    = bus_oe ? pc_word : '0;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL expose: clock  in  1  single rising-edge clock.
REQ-002 The block SHALL expose: reset_n  in  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-003 The block SHALL expose: stall  in  1  holds machine cycle at X3 while high.
REQ-004 The block SHALL expose: pc_word  in  4  PC nibble from the PC stack.
REQ-005 The block SHALL expose: pc_enable  in  1  PC stack has a valid nibble on pc_word.
REQ-006 The block SHALL expose: bus_in  in  4  ROM data returned on the shared 4-bit bus.
REQ-007 The block SHALL expose: cycle  out  3  machine subcycle to the PC stack (0=A1,1=A2,2=A3,3=M1,4=M2,5=X1,6=X2,7=X3).
REQ-008 The block SHALL expose: sync  out  1  high during X3, marks start of next instruction cycle.
REQ-009 The block SHALL expose: bus_out  out  4  address nibble driven to the bus.
REQ-010 The block SHALL expose: bus_oe  out  1  bus_out valid.
REQ-011 The block SHALL expose: opr  out  4  opcode nibble of the current instruction.
REQ-012 The block SHALL expose: opa  out  4  operand nibble of the current instruction.
REQ-013 The block SHALL expose: word2  out  8  second byte of a two-word instruction ({M1 nibble, M2 nibble}).
REQ-014 The block SHALL expose: two_word  out  1  current opr/opa is a two-word instruction.
REQ-015 The block SHALL expose: inst_valid  out  1  one-clock pulse, complete instruction available.

Function
REQ-016 cycle SHALL increment by 1 each clock, wrapping 7->0 (3-bit modulo).
REQ-017 When cycle==7 and stall==1, cycle SHALL hold at 7; stall SHALL be ignored for cycle values 0..6.
REQ-018 sync SHALL equal (cycle==7), combinational from the counter, high for every clock cycle is held at 7.
REQ-019 For cycle 0..2: bus_oe = pc_enable, bus_out = pc_word when pc_enable, else 4'h0.
REQ-020 For cycle 3..7: bus_oe=0, bus_out=4'h0.
REQ-021 At the clock edge ending cycle 3 (M1), bus_in SHALL be latched into an internal hi nibble register.
REQ-022 At the clock edge ending cycle 4 (M2), with pending==0: opr <= hi nibble, opa <= bus_in, two_word <= decode(hi, bus_in).
REQ-023 decode SHALL be 1 for opr in {0001 JCN, 0100 JUN, 0101 JMS, 0111 ISZ} or (opr==0010 and opa[0]==0, FIM); else 0.
REQ-024 At M2 end with pending==0: if decode==1 set pending<=1 and do not pulse inst_valid; else pulse inst_valid.
REQ-025 At M2 end with pending==1: word2 <= {hi nibble, bus_in}, pending <= 0, opr/opa/two_word unchanged, pulse inst_valid.
REQ-026 inst_valid SHALL be high for exactly the one clock in which cycle==5 following the qualifying M2; low otherwise.
REQ-027 word2 SHALL hold its value until the next second-word capture; single-word instructions SHALL NOT modify word2.
REQ-028 opr/opa SHALL remain stable from the M2 update until the next first-word M2.
REQ-029 The fetch state SHALL be two states: FIRST (pending=0) and SECOND (pending=1); transitions only at M2 end per REQ-024/025.

Reset
REQ-030 When reset_n==0 at a clock edge: cycle<=0, pending<=0, hi<=0, opr<=0, opa<=0, word2<=0, two_word<=0, inst_valid<=0, overriding stall and any in-progress fetch.
REQ-031 Immediately after reset release, outputs SHALL be cycle=0, sync=0, bus_oe=pc_enable, inst_valid=0; the first fetch begins at A1 with pending=0.
REQ-032 Reset asserted while pending==1 SHALL discard the first word; the next M2 is decoded as a first word.

Verification
REQ-033 Reset, then 16 clocks, stall=0 -> cycle sequence 0..7,0..7; sync high only at 7; bus_oe mirrors pc_enable only in cycles 0..2.
REQ-034 pc_word=4'hA, pc_enable=1 in A1 -> bus_out=4'hA, bus_oe=1; in M1 -> bus_out=0, bus_oe=0.
REQ-035 bus_in=4'hD at M1, 4'h3 at M2 (single-word) -> opr=D, opa=3, two_word=0, inst_valid=1 in the next cycle 5 only.
REQ-036 JUN: 4'h4,4'h1 then 4'h2,4'hF on the next fetch -> first fetch no inst_valid; second fetch opr=4, opa=1, word2=8'h2F, two_word=1, inst_valid pulse at its cycle 5.
REQ-037 FIM vs SRC: 4'h2,4'h4 -> two_word=1; 4'h2,4'h5 -> two_word=0, immediate inst_valid.
REQ-038 stall=1 for 5 clocks at cycle 7 -> cycle stays 7, sync high 5+ clocks, resumes at 0; reset_n=0 during a pending JMS -> next fetch 4'hB,4'h0 decodes as opr=B single-word.
